// File: rtl/vedic_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mul_pipe
// Purpose  : 3-stage valid/ready pipelined Urdhva-Tiryagbhyam multiplier with
//            per-transaction signed/unsigned mode and a sideband tag.
// Revision : 1.0  initial release
// ============================================================================
module vedic_mul_pipe #(
    parameter int WIDTH = 26,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   mul,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int c_H = WIDTH / 2;
    localparam logic [WIDTH-1:0]   c_ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] c_ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Stage registers
    logic                 r_s1_v, r_s2_v, r_s3_v;
    logic [TAG_W-1:0]     r_s1_tag, r_s2_tag;
    logic                 r_s1_neg, r_s2_neg;
    logic [WIDTH-1:0]     r_s1_amag, r_s1_bmag;
    logic [2*c_H-1:0]     r_pll, r_plh, r_phl, r_phh;
    logic [2*WIDTH-1:0]   r_mul;
    logic [TAG_W-1:0]     r_out_tag;

    // Handshake
    logic w_s3_space, w_s2_space;
    logic w_s2_adv, w_s1_adv, w_in_fire;

    assign w_s3_space = !r_s3_v || out_ready;
    assign w_s2_adv   = r_s2_v && w_s3_space;
    assign w_s2_space = !r_s2_v || w_s2_adv;
    assign w_s1_adv   = r_s1_v && w_s2_space;
    assign in_ready   = !r_s1_v || w_s1_adv;
    assign w_in_fire  = in_valid && in_ready;

    // Operand conditioning: in signed mode -2^(W-1) maps to 2^(W-1), still W bits
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_a_neg = signed_mode && a[WIDTH-1];
    assign w_b_neg = signed_mode && b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~a + c_ONE_W) : a;
    assign w_b_mag = w_b_neg ? (~b + c_ONE_W) : b;

    // Cross-term combination
    logic [2*c_H:0]     w_cross;
    logic [2*c_H:0]     w_mid;
    logic [1:0]         w_carry;
    logic [c_H-1:0]     w_hi;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_res;

    assign w_cross = {1'b0, r_plh} + {1'b0, r_phl};
    assign w_mid   = {1'b0, w_cross[2*c_H-1:0]}
                   + {1'b0, r_phh[c_H-1:0], r_pll[2*c_H-1:c_H]};
    // Both carries are summed so the upper quarter stays exact
    assign w_carry = {1'b0, w_cross[2*c_H]} + {1'b0, w_mid[2*c_H]};
    assign w_hi    = r_phh[2*c_H-1:c_H] + {{(c_H-2){1'b0}}, w_carry};
    assign w_prod  = {w_hi, w_mid[2*c_H-1:0], r_pll[c_H-1:0]};
    assign w_res   = r_s2_neg ? (~w_prod + c_ONE_2W) : w_prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s3_v    <= 1'b0;
            r_mul     <= '0;
            r_out_tag <= '0;
        end else begin
            if (in_ready) begin
                r_s1_v <= in_valid;
            end
            if (w_s2_space) begin
                r_s2_v <= r_s1_v;
            end
            if (w_s3_space) begin
                r_s3_v <= r_s2_v;
            end
            if (w_s2_adv) begin
                r_mul     <= w_res;
                r_out_tag <= r_s2_tag;
            end
        end
    end

    // Datapath registers carry no reset; their valid bits qualify them
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_tag  <= in_tag;
            r_s1_neg  <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_s1_amag <= w_a_mag;
            r_s1_bmag <= w_b_mag;
        end
        if (w_s1_adv) begin
            r_s2_tag <= r_s1_tag;
            r_s2_neg <= r_s1_neg;
            r_pll    <= {{c_H{1'b0}}, r_s1_amag[c_H-1:0]}
                      * {{c_H{1'b0}}, r_s1_bmag[c_H-1:0]};
            r_plh    <= {{c_H{1'b0}}, r_s1_amag[c_H-1:0]}
                      * {{c_H{1'b0}}, r_s1_bmag[2*c_H-1:c_H]};
            r_phl    <= {{c_H{1'b0}}, r_s1_amag[2*c_H-1:c_H]}
                      * {{c_H{1'b0}}, r_s1_bmag[c_H-1:0]};
            r_phh    <= {{c_H{1'b0}}, r_s1_amag[2*c_H-1:c_H]}
                      * {{c_H{1'b0}}, r_s1_bmag[2*c_H-1:c_H]};
        end
    end

    assign out_valid = r_s3_v;
    assign mul       = r_mul;
    assign out_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_vedic_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedic_mul_pipe
// Purpose  : Self-checking bench for vedic_mul_pipe at WIDTH=26 and WIDTH=8.
// Revision : 1.0  initial release
// ============================================================================
module tb_vedic_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        iv26, ir26, s26, ov26, or26;
    logic [25:0] a26, b26;
    logic [3:0]  it26, ot26;
    logic [51:0] m26;

    logic        iv8, ir8, s8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [3:0]  it8, ot8;
    logic [15:0] m8;

    vedic_mul_pipe #(.WIDTH(26), .TAG_W(4)) u_dut26 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv26), .in_ready(ir26),
        .a(a26), .b(b26), .signed_mode(s26), .in_tag(it26),
        .out_valid(ov26), .out_ready(or26), .mul(m26), .out_tag(ot26)
    );

    vedic_mul_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .signed_mode(s8), .in_tag(it8),
        .out_valid(ov8), .out_ready(or8), .mul(m8), .out_tag(ot8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] qm26[$];
    logic [3:0]  qt26[$];
    logic [63:0] qm8[$];
    logic [3:0]  qt8[$];
    int nout26 = 0;
    int nout8  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact product of the (optionally sign-extended) operands, kept to 2w bits
    function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input int w, input logic s);
        longint sx, sy;
        logic [63:0] mw;
        mw = (64'd1 << w) - 64'd1;
        sx = longint'(x & mw);
        sy = longint'(y & mw);
        if (s && x[w-1]) sx = sx - (longint'(1) << w);
        if (s && y[w-1]) sy = sy - (longint'(1) << w);
        return 64'(sx * sy) & ((64'd1 << (2*w)) - 64'd1);
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom % 8)
            0: r = 64'd0;
            1: r = '1;
            2: r = 64'd1 << (w-1);
            3: r = 64'd1;
            default: ;
        endcase
        return r & ((64'd1 << w) - 64'd1);
    endfunction

    // Scoreboards: expected results queued at input transfer, compared while out_valid
    logic [63:0] dm26, dm8;
    logic [3:0]  dt26, dt8;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ov26) begin
                if (qm26.size() == 0) begin
                    check("w26_unexpected_out", 64'(ov26), 64'd0);
                end else begin
                    check("w26_mul", 64'(m26), qm26[0]);
                    check("w26_tag", 64'(ot26), 64'(qt26[0]));
                    if (or26) begin
                        dm26 = qm26.pop_front();
                        dt26 = qt26.pop_front();
                        nout26++;
                    end
                end
            end
            if (iv26 && ir26) begin
                qm26.push_back(ref_mul(64'(a26), 64'(b26), 26, s26));
                qt26.push_back(it26);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ov8) begin
                if (qm8.size() == 0) begin
                    check("w8_unexpected_out", 64'(ov8), 64'd0);
                end else begin
                    check("w8_mul", 64'(m8), qm8[0]);
                    check("w8_tag", 64'(ot8), 64'(qt8[0]));
                    if (or8) begin
                        dm8 = qm8.pop_front();
                        dt8 = qt8.pop_front();
                        nout8++;
                    end
                end
            end
            if (iv8 && ir8) begin
                qm8.push_back(ref_mul(64'(a8), 64'(b8), 8, s8));
                qt8.push_back(it8);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load26(input int tagv);
        a26  = 26'(pick(26));
        b26  = 26'(pick(26));
        s26  = 1'($urandom % 2);
        it26 = 4'(tagv);
    endtask

    task automatic load8(input int tagv);
        a8  = 8'(pick(8));
        b8  = 8'(pick(8));
        s8  = 1'($urandom % 2);
        it8 = 4'(tagv);
    endtask

    int k, base, seen, tc26, tc8;
    logic took26, took8;
    logic [63:0] exp_first;

    initial begin
        rst_n = 1'b0;
        iv26 = 1'b0; a26 = '0; b26 = '0; s26 = 1'b0; it26 = '0; or26 = 1'b1;
        iv8  = 1'b0; a8  = '0; b8  = '0; s8  = 1'b0; it8  = '0; or8  = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(ov26), 64'd0);
        check("rst_mul",       64'(m26),  64'd0);
        check("rst_out_tag",   64'(ot26), 64'd0);
        check("rst_in_ready",  64'(ir26), 64'd1);
        check("rst8_out_valid", 64'(ov8), 64'd0);
        check("rst8_in_ready",  64'(ir8), 64'd1);

        // Unsigned all-ones, latency
        iv26 = 1'b1; a26 = 26'h3FFFFFF; b26 = 26'h3FFFFFF; s26 = 1'b0; it26 = 4'h5;
        tick();
        iv26 = 1'b0;
        check("lat_c1", 64'(ov26), 64'd0);
        tick();
        check("lat_c2", 64'(ov26), 64'd0);
        tick();
        check("lat_c3", 64'(ov26), 64'd1);
        check("t1_mul", 64'(m26), 64'h0FFFFFF8000001);
        check("t1_tag", 64'(ot26), 64'h5);
        tick();
        check("t1_done", 64'(ov26), 64'd0);

        // Signed back-to-back
        iv26 = 1'b1; s26 = 1'b1;
        a26 = 26'h3FFFFFD; b26 = 26'd5;       it26 = 4'd1; tick();
        a26 = 26'h2000000; b26 = 26'h2000000; it26 = 4'd2; tick();
        a26 = 26'h3FFFFFF; b26 = 26'h3FFFFFF; it26 = 4'd3; tick();
        iv26 = 1'b0;
        check("t2_v1",   64'(ov26), 64'd1);
        check("t2_mul1", 64'(m26),  64'h0FFFFFFFFFFFF1);
        check("t2_tag1", 64'(ot26), 64'd1);
        tick();
        check("t2_mul2", 64'(m26),  64'h04000000000000);
        check("t2_tag2", 64'(ot26), 64'd2);
        tick();
        check("t2_mul3", 64'(m26),  64'd1);
        check("t2_tag3", 64'(ot26), 64'd3);
        tick();
        check("t2_done", 64'(ov26), 64'd0);

        // Same operands, both modes
        iv26 = 1'b1; a26 = 26'h2000000; b26 = 26'd3;
        s26 = 1'b0; it26 = 4'd6; tick();
        s26 = 1'b1; it26 = 4'd7; tick();
        iv26 = 1'b0;
        tick();
        check("t3_unsigned", 64'(m26), 64'h6000000);
        tick();
        check("t3_signed",   64'(m26), 64'h0FFFFFFA000000);
        tick();

        // Backpressure
        or26 = 1'b0; iv26 = 1'b1; k = 0;
        load26(8); exp_first = ref_mul(64'(a26), 64'(b26), 26, s26);
        #1;
        for (int c = 0; c < 6; c++) begin
            took26 = iv26 && ir26;
            tick();
            if (took26) begin
                k++;
                if (k < 5) load26(8 + k); else iv26 = 1'b0;
            end
            #1;
        end
        check("t4_accepted", 64'(k), 64'd3);
        check("t4_in_ready_low", 64'(ir26), 64'd0);
        check("t4_out_valid", 64'(ov26), 64'd1);
        check("t4_mul_held", 64'(m26), exp_first);
        base = nout26;
        or26 = 1'b1;
        #1;
        check("t4_in_ready_release", 64'(ir26), 64'd1);
        for (int c = 0; c < 20; c++) begin
            if (k >= 5 && qm26.size() == 0 && !ov26) break;
            took26 = iv26 && ir26;
            tick();
            if (took26) begin
                k++;
                if (k < 5) load26(8 + k); else iv26 = 1'b0;
            end
            #1;
        end
        check("t4_all_out", 64'(nout26 - base), 64'd5);

        // Reset with two transactions in flight
        iv26 = 1'b1; load26(1); tick();
        load26(2); tick();
        iv26 = 1'b0; rst_n = 1'b0;
        tick();
        qm26.delete(); qt26.delete();
        rst_n = 1'b1;
        #1;
        check("t5_out_valid", 64'(ov26), 64'd0);
        check("t5_mul",       64'(m26),  64'd0);
        check("t5_out_tag",   64'(ot26), 64'd0);
        check("t5_in_ready",  64'(ir26), 64'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ov26) seen++;
        end
        check("t5_no_ghost", 64'(seen), 64'd0);

        // Randomised cross-check on both widths
        tc26 = 0; tc8 = 0;
        for (int c = 0; c < 1500; c++) begin
            took26 = iv26 && ir26;
            took8  = iv8 && ir8;
            tick();
            if (took26 || !iv26) begin
                iv26 = ($urandom % 4) != 0; load26(tc26); tc26++;
            end
            if (took8 || !iv8) begin
                iv8 = ($urandom % 4) != 0; load8(tc8); tc8++;
            end
            or26 = ($urandom % 3) != 0;
            or8  = ($urandom % 3) != 0;
            #1;
        end
        iv26 = 1'b0; iv8 = 1'b0; or26 = 1'b1; or8 = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        check("rnd26_drained", 64'(qm26.size()), 64'd0);
        check("rnd8_drained",  64'(qm8.size()),  64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
